wor_bus_arbiter: RTL and testbench

// Round-robin arbiter and sequencer for one shared wired-OR (wor) data bus driven by NUM_REQ requesters.

---
 rtl/wor_arb_pkg.sv | 11 +
 rtl/rr_pick.sv | 31 +++
 rtl/wor_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_wor_bus_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/wor_arb_pkg.sv
// Shared types and helpers for the wired-OR bus arbiter.
package wor_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, TURN} arb_state_t;

  // Counter/index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request after ptr, wrapping modulo NUM_REQ.
module rr_pick
  import wor_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PW      = clog2_min1(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [NUM_REQ-1:0] winner_o
);

  logic [PW-1:0] idx;

  // Walk the scan order backwards so the earliest candidate is written last.
  always_comb begin
    winner_o = '0;
    idx      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = PW'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[idx]) begin
        winner_o      = '0;
        winner_o[idx] = 1'b1;
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/wor_bus_arbiter.sv
// Round-robin owner sequencer for a shared wired-OR bus: bounded bursts, idle
// turnaround between owners, and readback contention detection.
module wor_bus_arbiter
  import wor_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_W     = 8,
  parameter  int MAX_BURST  = 4,
  parameter  int TURNAROUND = 1,
  localparam int PW         = clog2_min1(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             last,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] drv_data,
  input  logic [DATA_W-1:0]              bus_rd,
  input  logic                           clr_err,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [DATA_W-1:0]              bus_out,
  output logic [PW-1:0]                  bus_owner,
  output logic                           bus_idle,
  output logic                           collision,
  output logic                           err
);

  localparam int BW = clog2_min1(MAX_BURST);
  localparam int TW = clog2_min1(TURNAROUND);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURNAROUND - 1);

  arb_state_t         state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, owner_q, owner_d, pick_idx;
  logic [BW-1:0]      beat_q, beat_d;
  logic [TW-1:0]      turn_q, turn_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, pick_win;
  logic               coll_q, coll_d, err_q, err_d, pick_vld;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_vld),
    .winner_o(pick_win)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_win[i]) pick_idx = PW'(i);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    turn_d  = turn_q;
    gnt_d   = gnt_q;
    // Only the owner may be driving, so any readback difference is contention.
    coll_d  = (state_q == GRANT) && (bus_rd != drv_data[owner_q]);
    err_d   = coll_d | (err_q & ~clr_err);
    case (state_q)
      IDLE: if (pick_vld) begin
        gnt_d   = pick_win;
        owner_d = pick_idx;
        beat_d  = '0;
        state_d = GRANT;
      end
      GRANT: begin
        beat_d = beat_q + 1'b1;
        if (last[owner_q] || !req[owner_q] || beat_q == BEAT_LAST) begin
          gnt_d   = '0;
          ptr_d   = owner_q;
          turn_d  = '0;
          state_d = TURN;
        end
      end
      TURN: begin
        turn_d = turn_q + 1'b1;
        if (turn_q == TURN_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NUM_REQ - 1);
      owner_q <= '0;
      beat_q  <= '0;
      turn_q  <= '0;
      gnt_q   <= '0;
      coll_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      turn_q  <= turn_d;
      gnt_q   <= gnt_d;
      coll_q  <= coll_d;
      err_q   <= err_d;
    end
  end

  // Driven straight from the grant register so reset removes the driver at once.
  always_comb begin
    bus_out = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_q[i]) bus_out = bus_out | drv_data[i];
  end

  assign gnt       = gnt_q;
  assign bus_owner = owner_q;
  assign bus_idle  = ~|gnt_q;
  assign collision = coll_q;
  assign err       = err_q;

endmodule

// File: tb/tb_wor_bus_arbiter.sv
// Randomized scoreboard bench for wor_bus_arbiter against a timing-level ownership model.
module tb_wor_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
  localparam int TA = 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       req, last;
  logic [N-1:0][DW-1:0] drv_data;
  logic [DW-1:0]      bus_rd;
  logic               clr_err;
  logic [N-1:0]       gnt;
  logic [DW-1:0]      bus_out;
  logic [1:0]         bus_owner;
  logic               bus_idle, collision, err;

  wor_bus_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(MB), .TURNAROUND(TA)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .last(last), .drv_data(drv_data),
    .bus_rd(bus_rd), .clr_err(clr_err), .gnt(gnt), .bus_out(bus_out),
    .bus_owner(bus_owner), .bus_idle(bus_idle), .collision(collision), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [DW-1:0] bout;
    int            owner;
    bit            idle, coll, err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference: ownership as time intervals. An ownership ends after at most MB
  // cycles; the next arbitration may happen TA+1 edges after the ending edge.
  bit m_granted, m_err;
  int m_owner, m_ptr, m_cycles, m_free, cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_granted = 0; m_err = 0; m_owner = 0; m_ptr = N - 1; m_cycles = 0; m_free = cyc;
  endtask

  task automatic model_edge(output exp_t e);
    bit coll;
    coll  = m_granted && (bus_rd != drv_data[m_owner]);
    m_err = coll || (m_err && !clr_err);
    if (m_granted) begin
      m_cycles++;
      if (last[m_owner] || !req[m_owner] || m_cycles == MB) begin
        m_granted = 0;
        m_ptr     = m_owner;
        m_free    = cyc + TA + 1;
      end
    end else if (cyc >= m_free && req != '0) begin
      for (int k = 1; k <= N; k++) begin
        if (req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          break;
        end
      end
      m_granted = 1;
      m_cycles  = 0;
    end
    e.gnt   = m_granted ? N'(1 << m_owner) : '0;
    e.bout  = m_granted ? drv_data[m_owner] : '0;
    e.owner = m_owner;
    e.idle  = !m_granted;
    e.coll  = coll;
    e.err   = m_err;
    cyc++;
  endtask

  // Drive one cycle of inputs; the wired-OR readback follows the model's owner.
  task automatic apply(input logic [N-1:0] r, input logic [N-1:0] l, input bit corrupt, input bit clr);
    exp_t e;
    logic [DW-1:0] rd;
    req = r; last = l; clr_err = clr;
    for (int i = 0; i < N; i++) drv_data[i] = DW'($urandom);
    rd = m_granted ? drv_data[m_owner] : DW'($urandom);
    if (corrupt) rd = rd ^ (DW'(1) << $urandom_range(0, DW - 1));
    bus_rd = rd;
    model_edge(e);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [N-1:0] r, input logic [N-1:0] l, input bit corrupt, input bit clr);
    @(negedge clk);
    apply(r, l, corrupt, clr);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("gnt",       32'(gnt),       32'(e.gnt));
        chk("bus_out",   32'(bus_out),   32'(e.bout));
        chk("bus_owner", 32'(bus_owner), 32'(e.owner));
        chk("bus_idle",  32'(bus_idle),  32'(e.idle));
        chk("collision", 32'(collision), 32'(e.coll));
        chk("err",       32'(err),       32'(e.err));
      end
    end
  end

  initial begin
    bit found;
    cyc = 0;
    rst_n = 1'b0; req = '1; last = '0; clr_err = 1'b0; bus_rd = '0; drv_data = '0;
    model_reset();
    #7;
    chk("rst_gnt",   32'(gnt),       32'h0);
    chk("rst_bus",   32'(bus_out),   32'h0);
    chk("rst_owner", 32'(bus_owner), 32'h0);
    chk("rst_idle",  32'(bus_idle),  32'h1);
    chk("rst_coll",  32'(collision), 32'h0);
    chk("rst_err",   32'(err),       32'h0);

    // Release with all requesting: index 0 must win first.
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply('1, '0, 0, 0);

    repeat (40) step('1, '0, 0, 0);

    repeat (600) step(N'($urandom_range(0, 15)), N'($urandom & $urandom),
                      $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);

    repeat (20) step(4'b1000, '0, 0, 0);
    repeat (10) step(4'b0100, 4'b0100, 0, 0);

    // Asynchronous reset while the owner is on its second beat.
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      step('1, '0, 0, 0);
      found = m_granted && m_cycles == 1;
    end
    chk("midburst_reached", 32'(found), 32'h1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_gnt",  32'(gnt),      32'h0);
    chk("async_bus",  32'(bus_out),  32'h0);
    chk("async_idle", 32'(bus_idle), 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply('1, '0, 0, 0);
    repeat (12) step('1, '0, 0, 0);

    repeat (2) @(posedge clk);
    #4;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
